// File: rtl/display_formatter.sv
// Binary-to-display-digit formatter: hex pass-through or sequential double-dabble
// decimal conversion, with start/done handshake, overflow and leading-zero blanking.
module display_formatter #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode_hex,
    input  logic [IN_WIDTH-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int NDEC = (IN_WIDTH + 2) / 3;
    localparam int NINT = (DIGITS > NDEC) ? DIGITS : NDEC;
    localparam int BW   = 4 * NINT;
    localparam int DW   = 4 * DIGITS;
    localparam int XW   = (IN_WIDTH > DW) ? IN_WIDTH : DW;
    localparam int CW   = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0]     LAST_ITER = CW'(IN_WIDTH);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] val_q;
    logic                mode_q;
    logic [BW-1:0]       bcd_q, bcd_adj, bcd_next;
    logic [CW-1:0]       cnt_q;
    logic [DW-1:0]       digits_q, res_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                overflow_q, ovf_d;
    logic [XW-1:0]       val_ext;
    logic                last_iter, accept, finish_en;

    assign last_iter = (cnt_q == LAST_ITER);
    assign accept    = start && ((state_q == IDLE) || (state_q == FINISH));
    assign finish_en = (state_q == LOAD) || ((state_q == SHIFT) && last_iter);

    // Shift-add-3: correct every digit >=5 before the doubling shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NINT; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BW-2:0], val_q[IN_WIDTH-1]};
    end

    assign val_ext = XW'(val_q);

    // Result selection; blanking works on the truncated, displayed digits.
    always_comb begin
        if (mode_q) begin
            res_d = val_ext[DW-1:0];
            ovf_d = |(val_ext >> DW);
        end else begin
            res_d = bcd_q[DW-1:0];
            ovf_d = |(bcd_q >> DW);
        end
        blank_d = '0;
        for (int k = 1; k < DIGITS; k++) begin
            blank_d[k] = ((res_d >> (4*k)) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = mode_hex ? LOAD : SHIFT;
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = FINISH;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_iter) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = start ? (mode_hex ? LOAD : SHIFT) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q      <= '0;
            mode_q     <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            digits_q   <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                val_q  <= value;
                mode_q <= mode_hex;
                bcd_q  <= '0;
                cnt_q  <= '0;
            end else if ((state_q == SHIFT) && !last_iter) begin
                bcd_q <= bcd_next;
                val_q <= val_q << 1;
                cnt_q <= cnt_q + CW'(1);
            end
            // Visible outputs change only here, so done and new data coincide.
            if (finish_en) begin
                digits_q   <= res_d;
                blank_q    <= blank_d;
                overflow_q <= ovf_d;
            end
        end
    end

    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule
